// File: rtl/button_controller_pkg.sv
// Shared constants and types for the tea-timer button front-end.
//   NUM_BUTTONS / BTN_* : channel indices into button_n
//   DEF_*               : product default debounce / auto-repeat settings
//   lock_state_t        : lockout FSM state encoding
//   lowest_set()        : priority pick, lowest index wins
package teatimer_pkg;

  localparam int unsigned NUM_BUTTONS   = 4;
  localparam int unsigned BTN_RESET     = 0;
  localparam int unsigned BTN_STARTSTOP = 1;
  localparam int unsigned BTN_INCMIN    = 2;
  localparam int unsigned BTN_INCSEC    = 3;

  localparam int unsigned DEF_DEBOUNCE_COUNT = 20;
  localparam int unsigned DEF_REPEAT_DELAY   = 500;
  localparam int unsigned DEF_REPEAT_PERIOD  = 100;
  localparam logic [NUM_BUTTONS-1:0] DEF_REPEAT_MASK = 4'b1100;

  typedef logic [1:0] btn_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } lock_state_t;

  // Index of the lowest set bit; '0 when none set (callers gate on |v).
  function automatic btn_idx_t lowest_set(input logic [NUM_BUTTONS-1:0] v);
    lowest_set = '0;
    for (int unsigned i = NUM_BUTTONS; i > 0; i--) begin
      if (v[i-1]) lowest_set = btn_idx_t'(i - 1);
    end
  endfunction

endpackage

// File: rtl/button_controller_if.sv
// Button pins in, timer control strobes out.
//   button_n       : raw active-low buttons [0]=reset [1]=startstop [2]=incmin [3]=incsec
//   ctrl_*         : one-cycle strobes toward the timer
//   any_held       : accepted button still debounced-pressed
// master = board/pin side, slave = button_controller.
interface button_controller_if;
  import teatimer_pkg::*;

  logic [NUM_BUTTONS-1:0] button_n;
  logic                   ctrl_reset;
  logic                   ctrl_startstop;
  logic                   ctrl_incmin;
  logic                   ctrl_incsec;
  logic                   any_held;

  modport master (
    output button_n,
    input  ctrl_reset, ctrl_startstop, ctrl_incmin, ctrl_incsec, any_held
  );

  modport slave (
    input  button_n,
    output ctrl_reset, ctrl_startstop, ctrl_incmin, ctrl_incsec, any_held
  );

endinterface

// File: rtl/button_controller_debounce.sv
// Single-channel 2-flop synchroniser plus debounce counter.
//   clk, reset : system clock, asynchronous active-low reset
//   button_n   : raw asynchronous active-low button
//   stable     : debounced level (1 = released)
//   flip       : high in the cycle whose rising edge will toggle stable,
//                so the owner can register a strobe on that same edge
module button_debounce #(
  parameter int unsigned DEBOUNCE_COUNT = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic stable,
  output logic flip
);

  localparam int unsigned CW = $clog2(DEBOUNCE_COUNT + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  assign flip = (s2 != stable) && (cnt == CW'(DEBOUNCE_COUNT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      s1 <= button_n;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_controller.sv
// Tea-timer button front-end: debounce, one-at-a-time lockout, auto-repeat.
//   clk            : system clock (1 kHz in product)
//   reset          : asynchronous active-low reset
//   btn_if.slave   : button_n in; ctrl_reset/startstop/incmin/incsec strobes
//                    and any_held out
module button_controller
  import teatimer_pkg::*;
#(
  parameter int unsigned            debounce_count = DEF_DEBOUNCE_COUNT,
  parameter int unsigned            repeat_delay   = DEF_REPEAT_DELAY,
  parameter int unsigned            repeat_period  = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BUTTONS-1:0] repeat_mask    = DEF_REPEAT_MASK
) (
  input logic                clk,
  input logic                reset,
  button_controller_if.slave btn_if
);

  localparam int unsigned REP_MAX = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] flip;
  logic [NUM_BUTTONS-1:0] press_evt;
  logic [NUM_BUTTONS-1:0] release_evt;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_COUNT(debounce_count)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .button_n(btn_if.button_n[i]),
      .stable  (stable[i]),
      .flip    (flip[i])
    );
  end

  // Edge-triggered acceptance: only a fresh press can take ownership, so a
  // channel locked out while another owned stays silent until it releases.
  assign press_evt   = flip & stable;
  assign release_evt = flip & ~stable;

  lock_state_t            state_q, state_d;
  btn_idx_t               owner_q, owner_d;
  logic [RW-1:0]          rep_cnt_q, rep_cnt_d;
  logic                   rep_phase_q, rep_phase_d;
  logic [NUM_BUTTONS-1:0] strobe_q, strobe_d;
  logic [RW-1:0]          rep_target;

  // First repeat waits repeat_delay; later ones repeat_period.
  assign rep_target = rep_phase_q ? RW'(repeat_period) : RW'(repeat_delay);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      strobe_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      strobe_q    <= strobe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    strobe_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|press_evt) begin
          owner_d           = lowest_set(press_evt);
          strobe_d[owner_d] = 1'b1;
          state_d           = ST_OWNED;
          rep_cnt_d         = '0;
          rep_phase_d       = 1'b0;
        end
      end
      ST_OWNED: begin
        // Release wins over a repeat falling on the same edge.
        if (release_evt[owner_q]) begin
          state_d     = ST_IDLE;
          rep_cnt_d   = '0;
          rep_phase_d = 1'b0;
        end else if (repeat_mask[owner_q]) begin
          if (rep_cnt_q == rep_target - RW'(1)) begin
            strobe_d[owner_q] = 1'b1;
            rep_cnt_d         = '0;
            rep_phase_d       = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign btn_if.ctrl_reset     = strobe_q[BTN_RESET];
  assign btn_if.ctrl_startstop = strobe_q[BTN_STARTSTOP];
  assign btn_if.ctrl_incmin    = strobe_q[BTN_INCMIN];
  assign btn_if.ctrl_incsec    = strobe_q[BTN_INCSEC];
  assign btn_if.any_held       = (state_q == ST_OWNED);

endmodule
